key_expand: RTL and testbench

Sequential AES-128 key schedule: accepts a 128-bit cipher key, generates all 11 round keys one per cycle, and stores them in an internal key table. It sits directly upstream of the combinational `round` stage and supplies its `key_i`. The round controller indexes keys forward (0→10) for encryption and backward (10→0) for decryption. Round keys use the same row-major byte layout as the `round` state: {row0, row1, row2, row3}, 32 bits per row, column 0 in the MSBs.

---
 rtl/key_expand_if.sv | 25 ++
 rtl/key_expand.sv | 143 ++++++++++++++
 tb/tb_key_expand.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/key_expand_if.sv
// Bus between the round controller and the AES-128 key schedule.
// The zeroize_i signal exists only when KEY_EXP_ZEROIZE_EN is defined.
interface key_expand_if;
  logic         start_i;
  logic [127:0] key_i;
  logic [3:0]   rk_idx_i;
  logic [127:0] rk_o;
  logic         busy_o;
  logic         ready_o;
`ifdef KEY_EXP_ZEROIZE_EN
  logic         zeroize_i;
`endif

`ifdef KEY_EXP_ZEROIZE_EN
  modport master (output start_i, key_i, rk_idx_i, zeroize_i,
                  input  rk_o, busy_o, ready_o);
  modport slave  (input  start_i, key_i, rk_idx_i, zeroize_i,
                  output rk_o, busy_o, ready_o);
`else
  modport master (output start_i, key_i, rk_idx_i,
                  input  rk_o, busy_o, ready_o);
  modport slave  (input  start_i, key_i, rk_idx_i,
                  output rk_o, busy_o, ready_o);
`endif
endinterface

// File: rtl/key_expand.sv
// Sequential AES-128 key schedule: one round key per cycle into an 11-slot table.
// Optional KEY_EXP_ZEROIZE_EN adds a one-cycle table clear via zeroize_i.
module key_expand (
  input  logic         clk_i,
  input  logic         rst_i,
  key_expand_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t       r_state, w_state_next;
  logic [3:0]   r_rc;
  logic [127:0] r_table [0:10];   // word order: {w0, w1, w2, w3}
  logic         w_zero, w_load;
  logic [127:0] w_prev, w_next_slot, w_rd;
  logic [31:0]  w_w3_rot, w_t, w_n0, w_n1, w_n2, w_n3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse as x^254 (0 maps to 0), then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    case (rc)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Row-major <-> column-word layout; the 4x4 byte transpose is its own inverse.
  function automatic logic [127:0] transpose(input logic [127:0] a);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-32*r-8*c -: 8] = a[127-32*c-8*r -: 8];
    return o;
  endfunction

`ifdef KEY_EXP_ZEROIZE_EN
  assign w_zero = bus.zeroize_i;
`else
  assign w_zero = 1'b0;
`endif
  assign w_load = bus.start_i && (r_state != EXPAND);

  always_comb begin
    w_prev = '0;
    for (int i = 0; i < 10; i++)
      if (r_rc == 4'(i + 1)) w_prev = r_table[i];
  end

  assign w_w3_rot    = {w_prev[23:0], w_prev[31:24]};
  assign w_t         = sub_word(w_w3_rot) ^ {rcon(r_rc), 24'h0};
  assign w_n0        = w_prev[127:96] ^ w_t;
  assign w_n1        = w_prev[95:64]  ^ w_n0;
  assign w_n2        = w_prev[63:32]  ^ w_n1;
  assign w_n3        = w_prev[31:0]   ^ w_n2;
  assign w_next_slot = {w_n0, w_n1, w_n2, w_n3};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: if (bus.start_i) w_state_next = EXPAND;
      EXPAND:     if (r_rc == 4'd10) w_state_next = DONE;
      default:    w_state_next = IDLE;
    endcase
    if (w_zero) w_state_next = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 11; i++) r_table[i] <= '0;
      r_rc <= '0;
    end else if (w_zero) begin
      for (int i = 0; i < 11; i++) r_table[i] <= '0;
      r_rc <= '0;
    end else if (w_load) begin
      r_table[0] <= transpose(bus.key_i);
      r_rc       <= 4'd1;
    end else if (r_state == EXPAND) begin
      for (int i = 1; i < 11; i++)
        if (r_rc == 4'(i)) r_table[i] <= w_next_slot;
      r_rc <= r_rc + 4'd1;
    end
  end

  // Out-of-range indices fall through to zero.
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < 11; i++)
      if (bus.rk_idx_i == 4'(i)) w_rd = r_table[i];
  end

  assign bus.rk_o    = (r_state == DONE) ? transpose(w_rd) : 128'h0;
  assign bus.busy_o  = (r_state == EXPAND);
  assign bus.ready_o = (r_state == DONE);
endmodule

// File: tb/tb_key_expand.sv
// Scoreboard bench for key_expand: stimulus queues expected outputs, a negedge monitor compares.
// Build with KEY_EXP_ZEROIZE_EN to also exercise zeroize_i.
module tb_key_expand;
  logic clk = 1'b0;
  logic rst = 1'b1;

  key_expand_if bus();

  key_expand dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] rk;
    logic         busy;
    logic         ready;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_R1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] SEQ_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  // FIPS word order to the row-major layout the DUT uses on its ports.
  function automatic logic [127:0] rm(input logic [127:0] a);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-32*r-8*c -: 8] = a[127-32*c-8*r -: 8];
    return o;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      if (bus.rk_o === e.rk && bus.busy_o === e.busy && bus.ready_o === e.ready) begin
        n_pass++;
        $display("ok   %s rk=%h busy=%b ready=%b", e.name, bus.rk_o, bus.busy_o, bus.ready_o);
      end else begin
        $display("FAIL %s got rk=%h busy=%b ready=%b, expected rk=%h busy=%b ready=%b",
                 e.name, bus.rk_o, bus.busy_o, bus.ready_o, e.rk, e.busy, e.ready);
      end
    end
  end

  task automatic expect_out(input string nm, input logic [3:0] idx,
                            input logic [127:0] rk, input logic b, input logic r);
    exp_t e;
    e.name = nm; e.rk = rk; e.busy = b; e.ready = r;
    bus.rk_idx_i = idx;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  // Pulse start, then track busy for the 10 expansion cycles; optionally
  // re-issue start with another key at E4, which must be ignored.
  task automatic run_expand(input logic [127:0] key_rm, input string nm,
                            input bit poke, input logic [127:0] poke_key);
    bus.key_i   = key_rm;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (poke && k == 3) begin
        bus.key_i   = poke_key;
        bus.start_i = 1'b1;
      end
      expect_out($sformatf("%s_busy%0d", nm, k), 4'd0, 128'h0, 1'b1, 1'b0);
      bus.start_i = 1'b0;
    end
  endtask

  initial begin
    bus.start_i  = 1'b0;
    bus.key_i    = '0;
    bus.rk_idx_i = '0;
`ifdef KEY_EXP_ZEROIZE_EN
    bus.zeroize_i = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    expect_out("rst_held", 4'd0, 128'h0, 1'b0, 1'b0);
    rst = 1'b0;
    expect_out("reset_idx0",  4'd0,  128'h0, 1'b0, 1'b0);
    expect_out("reset_idx5",  4'd5,  128'h0, 1'b0, 1'b0);
    expect_out("reset_idx10", 4'd10, 128'h0, 1'b0, 1'b0);
    expect_out("reset_idx15", 4'd15, 128'h0, 1'b0, 1'b0);

    run_expand(rm(FIPS_KEY), "fips", 1'b0, '0);
    expect_out("fips_idx0",  4'd0,  rm(FIPS_KEY), 1'b0, 1'b1);
    expect_out("fips_idx1",  4'd1,  rm(FIPS_R1),  1'b0, 1'b1);
    expect_out("fips_idx2",  4'd2,  rm(FIPS_R2),  1'b0, 1'b1);
    expect_out("fips_idx10", 4'd10, rm(FIPS_R10), 1'b0, 1'b1);
    expect_out("fips_idx11", 4'd11, 128'h0,       1'b0, 1'b1);

    // Reload from DONE; ready drops on the first busy cycle. A start at E4 is ignored.
    run_expand(rm(SEQ_KEY), "reload", 1'b1, rm(FIPS_KEY));
    expect_out("reload_idx0",  4'd0,  rm(SEQ_KEY), 1'b0, 1'b1);
    expect_out("reload_idx1",  4'd1,  rm(SEQ_R1),  1'b0, 1'b1);
    expect_out("reload_idx10", 4'd10, rm(SEQ_R10), 1'b0, 1'b1);
    expect_out("reload_idx12", 4'd12, 128'h0,      1'b0, 1'b1);
    expect_out("reload_idx15", 4'd15, 128'h0,      1'b0, 1'b1);

    // Reset in the middle of an expansion.
    bus.key_i   = rm(FIPS_KEY);
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    for (int k = 0; k < 5; k++)
      expect_out($sformatf("mid_busy%0d", k), 4'd0, 128'h0, 1'b1, 1'b0);
    rst = 1'b1;
    expect_out("mid_rst_a", 4'd0, 128'h0, 1'b0, 1'b0);
    expect_out("mid_rst_b", 4'd10, 128'h0, 1'b0, 1'b0);
    rst = 1'b0;
    expect_out("post_rst_idle", 4'd10, 128'h0, 1'b0, 1'b0);
    run_expand(rm(SEQ_KEY), "fresh", 1'b0, '0);
    expect_out("fresh_idx0",  4'd0,  rm(SEQ_KEY), 1'b0, 1'b1);
    expect_out("fresh_idx10", 4'd10, rm(SEQ_R10), 1'b0, 1'b1);

`ifdef KEY_EXP_ZEROIZE_EN
    bus.zeroize_i = 1'b1;
    bus.start_i   = 1'b1;
    bus.key_i     = rm(FIPS_KEY);
    @(posedge clk); #1;
    bus.zeroize_i = 1'b0;
    bus.start_i   = 1'b0;
    expect_out("zero_idx0",  4'd0,  128'h0, 1'b0, 1'b0);
    expect_out("zero_idx10", 4'd10, 128'h0, 1'b0, 1'b0);
    expect_out("zero_still", 4'd1,  128'h0, 1'b0, 1'b0);
`endif

    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain got %0d pending entries, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
